// File: rtl/mem_writer.sv
// rtl/mem_writer.sv - sequential burst writer for the single-port memory write port
//
// Accepts a burst command (base address, word count) and then writes one
// word per accepted stream beat into consecutive, wrapping memory addresses.
// Each write is registered, so a word accepted at edge Ek is presented on
// the memory write port from Ek until Ek+1.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      burst request, only looked at while idle
//   base_addr  first write address, latched with an accepted start
//   length     burst length in words, 0 .. 2**addrwidth
//   abort      ends the burst early; a word accepted in the same cycle still lands
//   in_valid   source has a word
//   in_ready   writer takes a word this cycle
//   in_data    word to write
//   mem_we     registered memory write enable
//   mem_addr   registered memory write address
//   mem_wdata  registered memory write data
//   busy       burst in progress or finishing
//   done       one-cycle pulse when the burst has finished
//   count      words accepted in the current or most recent burst

module mem_writer #(
   parameter int addrwidth   = 12,
   parameter int datawidth_p = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [addrwidth-1:0]   base_addr,
   input  logic [addrwidth:0]     length,
   input  logic                   abort,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [datawidth_p-1:0] in_data,
   output logic                   mem_we,
   output logic [addrwidth-1:0]   mem_addr,
   output logic [datawidth_p-1:0] mem_wdata,
   output logic                   busy,
   output logic                   done,
   output logic [addrwidth:0]     count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [addrwidth-1:0] addr_one = {{(addrwidth-1){1'b0}}, 1'b1};
   localparam logic [addrwidth:0]   cnt_one  = {{addrwidth{1'b0}}, 1'b1};

   state_t                state;
   state_t                state_next;
   logic [addrwidth-1:0]  addr_cnt;
   logic [addrwidth:0]    remaining;
   logic                  handshake;

   // Derived straight from the state so it never depends on in_ready and
   // cannot form a loop with the next-state logic.
   assign handshake = in_valid && (state == WRITE);

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               // A zero-length burst skips WRITE and only produces the done pulse.
               state_next = (length == '0) ? DONE : WRITE;
            end
         end
         WRITE: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if ((in_valid && (remaining == cnt_one)) || abort) begin
               state_next = DONE;
            end
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         addr_cnt  <= '0;
         remaining <= '0;
         count     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state  <= state_next;
         mem_we <= handshake;
         if (handshake) begin
            mem_addr  <= addr_cnt;
            mem_wdata <= in_data;
            // Natural overflow of the address counter gives the wrap to 0.
            addr_cnt  <= addr_cnt + addr_one;
            remaining <= remaining - cnt_one;
            count     <= count + cnt_one;
         end else if ((state == IDLE) && start) begin
            addr_cnt  <= base_addr;
            remaining <= length;
            count     <= '0;
         end
      end
   end

endmodule

// File: doc/mem_writer.md
# mem_writer

Sequential burst writer for the single-port synchronous memory array used throughout the design (`2**addrwidth` words of `datawidth_p` bits, read via `clk`/`addr`/`data_out`). Accepts a burst command (base address, word count), then consumes a valid/ready data stream and issues one registered write per accepted word at consecutive, wrapping addresses. It is the write-side counterpart of the memory read path and sits between a data source (DMA, loader, testbench driver) and the memory write port.

## Interface
- `addrwidth`, 12, memory address width; depth is `2**addrwidth`
- `datawidth_p`, 32, data word width

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  burst request, sampled only in IDLE
- `base_addr`  in  addrwidth  first write address, latched on accepted `start`
- `length`  in  addrwidth+1  words in burst, 0..`2**addrwidth`, latched on accepted `start`
- `abort`  in  1  terminate burst early, honoured only in WRITE
- `in_valid`  in  1  source has a word
- `in_ready`  out  1  writer accepts a word this cycle
- `in_data`  in  datawidth_p  word to write
- `mem_we`  out  1  memory write enable, registered
- `mem_addr`  out  addrwidth  memory write address, registered
- `mem_wdata`  out  datawidth_p  memory write data, registered
- `busy`  out  1  high in WRITE and DONE
- `done`  out  1  one-cycle pulse, burst finished
- `count`  out  addrwidth+1  words accepted in current/last burst

## Operation
- States: IDLE, WRITE, DONE. Reset state IDLE.
- IDLE: `in_ready`=0. On `start`=1: latch `base_addr` to the address counter, `length` to the remaining counter, clear `count`. Next state WRITE if `length`!=0, else DONE.
- WRITE: `in_ready`=1 (combinational from state). Handshake = `in_valid & in_ready`. On handshake: register `mem_we`=1, `mem_addr`=address counter, `mem_wdata`=`in_data`; address counter +1 mod `2**addrwidth` (0xFFF -> 0x000 at default width); remaining -1; `count` +1. Without handshake `mem_we`=0 next cycle; `mem_addr`/`mem_wdata` hold.
- WRITE -> DONE when the handshake consumes the last word (remaining==1), or when `abort`=1. `abort` and handshake in the same cycle: the word is written and counted, then DONE.
- DONE: `in_ready`=0, `done`=1 for exactly this one cycle, then IDLE.
- `start` in WRITE or DONE is ignored (no queueing). `abort` outside WRITE is ignored.
- `count` holds its final value from DONE until the next accepted `start`; `length`=`2**addrwidth` yields `count`=`2**addrwidth`.
- Reset mid-burst: state IDLE, burst abandoned, no `mem_we` after the reset edge; in-flight source data is dropped.
- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `count`=0.

## Timing
- `start` sampled at edge E0 -> `busy`=1 and `in_ready`=1 from E0 (first handshake possible at E1).
- Handshake at edge Ek -> `mem_we`/`mem_addr`/`mem_wdata` valid from Ek until Ek+1; memory captures at Ek+1. Write latency 1 cycle from acceptance.
- Continuous `in_valid` sustains one write per cycle; no bubbles inside a burst.
- Last handshake at edge EL -> `done`=1 and last `mem_we`=1 in the same cycle (EL..EL+1); `busy`=0 from EL+1; a new `start` can be accepted at EL+2.
- `length`=0: `start` at E0 -> `done`=1 from E0 to E1, no `mem_we`, `busy`=0 from E1.
- A read of the same address through the read port returns the new data when the read address is sampled at or after Ek+1.

## Test plan
- Reset, `start` base 0x010 length 4, `in_valid` held with data 0xA0..0xA3 -> `mem_we` on 4 consecutive cycles at 0x010..0x013 with 0xA0..0xA3; `done` coincident with 4th write; `count`=4; read-back matches.
- Wrap: base 0xFFE length 4 -> writes at 0xFFE, 0xFFF, 0x000, 0x001, in order.
- Backpressure: length 3, `in_valid` pattern 1,0,0,1,0,1 -> `mem_we` only one cycle after each handshake, data order preserved, `done` after 3rd write, `start` pulses during burst ignored.
- Length 0 -> one-cycle `done`, no `mem_we`, `count`=0; length 4096 -> 4096 writes covering all addresses, `count`=4096.
- `abort` asserted with 2nd handshake of a length-8 burst -> 2 writes, `done` next cycle, `count`=2, no further `in_ready`.
- `rst` asserted after 3 of 8 words -> all outputs at reset values next cycle, no later `mem_we`; subsequent burst behaves normally.
